instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 186 ++++++++++++++++++
 tb/tb_instr_mem_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Instruction memory with a byte-stream program loader and a stallable fetch port.
// Optional `IMEM_FETCH_FAULT_EN: misaligned/out-of-range fetches return a NOP with f_fault set.
module instr_mem_loader #(
   parameter int ADDRW = 10
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             ld_start,
   input  logic             ld_valid,
   input  logic [7:0]       ld_byte,
   input  logic             ld_end,
   output logic             ld_busy,
   output logic             ld_done,
   output logic             ld_overflow,
   output logic [ADDRW:0]   ld_words,
   input  logic             f_req,
   input  logic [31:0]      f_addr,
   output logic             f_ready,
   input  logic             f_stall,
   output logic             f_valid,
   output logic [31:0]      f_instr,
   output logic [31:0]      f_pc,
   output logic             f_fault
);

   typedef enum logic {S_IDLE, S_LOAD} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_enter_load;
   logic             w_end_acc;
   logic             w_load;

   logic [1:0]       r_idx;
   logic [ADDRW:0]   r_ptr;
   logic [31:0]      r_asm;
   logic             r_overflow;
   logic             r_done;

   logic             w_full;
   logic             w_byte_ok;
   logic [31:0]      w_asm_fill;
   logic [31:0]      w_asm_next;
   logic [1:0]       w_idx_next;
   logic             w_word_done;
   logic             w_we;

   logic [31:0]      r_mem [2**ADDRW];
   logic [31:0]      r_rdata;
   logic             r_f_valid;
   logic [31:0]      r_f_pc;
   logic             w_f_ready;
   logic             w_f_acc;
   logic             w_rd_en;

   always_ff @(posedge clk) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_enter_load = 1'b0;
      w_end_acc    = 1'b0;
      w_load       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (ld_start) begin
               w_state_nxt  = S_LOAD;
               w_enter_load = 1'b1;
            end
         end
         S_LOAD: begin
            w_load = 1'b1;
            if (ld_end) begin
               w_state_nxt = S_IDLE;
               w_end_acc   = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Pointer MSB marks the memory as full; bytes after that are dropped.
   assign w_full    = r_ptr[ADDRW];
   assign w_byte_ok = w_load & ld_valid & ~w_full;

   always_comb begin
      w_asm_fill = r_asm;
      case (r_idx)
         2'd0:    w_asm_fill[7:0]   = ld_byte;
         2'd1:    w_asm_fill[15:8]  = ld_byte;
         2'd2:    w_asm_fill[23:16] = ld_byte;
         default: w_asm_fill[31:24] = ld_byte;
      endcase
   end

   assign w_asm_next  = w_byte_ok ? w_asm_fill : r_asm;
   assign w_idx_next  = w_byte_ok ? r_idx + 2'd1 : r_idx;
   assign w_word_done = w_byte_ok && (r_idx == 2'd3);
   // A byte landing with ld_end is folded in first, so at most one write per cycle.
   assign w_we        = rstn && (w_word_done || (w_end_acc && (w_idx_next != 2'd0)));

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_idx      <= 2'd0;
         r_ptr      <= '0;
         r_overflow <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= w_end_acc;
         if (w_enter_load) begin
            r_idx      <= 2'd0;
            r_ptr      <= '0;
            r_overflow <= 1'b0;
         end else if (w_load) begin
            r_idx <= w_end_acc ? 2'd0 : w_idx_next;
            if (w_we)
               r_ptr <= r_ptr + (ADDRW+1)'(1);
            if (ld_valid && w_full)
               r_overflow <= 1'b1;
         end
      end
   end

   // Unfilled lanes must read as zero, so the assembly register restarts clean.
   always_ff @(posedge clk) begin
      if (w_enter_load || w_we || w_end_acc) r_asm <= '0;
      else                                   r_asm <= w_asm_next;
   end

   always_ff @(posedge clk) begin
      if (w_we) r_mem[r_ptr[ADDRW-1:0]] <= w_asm_next;
   end

   assign w_f_ready = ~w_load & ~(r_f_valid & f_stall);
   assign w_f_acc   = f_req & w_f_ready;

`ifdef IMEM_FETCH_FAULT_EN
   localparam logic [31:0] NOP = 32'h0000_0013;
   logic w_addr_fault;
   logic r_f_fault;

   assign w_addr_fault = (f_addr[1:0] != 2'b00) | (|f_addr[31:ADDRW+2]);
   assign w_rd_en      = w_f_acc & ~w_addr_fault;

   always_ff @(posedge clk) begin
      if (!rstn)        r_f_fault <= 1'b0;
      else if (w_f_acc) r_f_fault <= w_addr_fault;
   end

   assign f_instr = r_f_fault ? NOP : r_rdata;
   assign f_fault = r_f_fault;
`else
   assign w_rd_en = w_f_acc;
   assign f_instr = r_rdata;
   assign f_fault = 1'b0;
`endif

   // Read register only advances on an accepted fetch, which also holds it under stall.
   always_ff @(posedge clk) begin
      if (!rstn)        r_rdata <= '0;
      else if (w_rd_en) r_rdata <= r_mem[f_addr[ADDRW+1:2]];
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_f_valid <= 1'b0;
         r_f_pc    <= '0;
      end else if (w_f_acc) begin
         r_f_valid <= 1'b1;
         r_f_pc    <= f_addr;
      end else if (!f_stall) begin
         r_f_valid <= 1'b0;
      end
   end

   assign ld_busy     = w_load;
   assign ld_done     = r_done;
   assign ld_overflow = r_overflow;
   assign ld_words    = r_ptr;
   assign f_ready     = w_f_ready;
   assign f_valid     = r_f_valid;
   assign f_pc        = r_f_pc;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: u_dut0 uses ADDRW=10, u_dut1 uses ADDRW=2 for the overflow case.
module tb_instr_mem_loader;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn;
   logic [1:0]  ld_start, ld_valid, ld_end, ld_busy, ld_done, ld_overflow;
   logic [1:0]  f_req, f_ready, f_stall, f_valid, f_fault;
   logic [7:0]  ld_byte [2];
   logic [31:0] f_addr  [2];
   logic [31:0] f_instr [2];
   logic [31:0] f_pc    [2];
   logic [10:0] ld_words0;
   logic [2:0]  ld_words1;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] p35 [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

   instr_mem_loader #(.ADDRW(10)) u_dut0 (
      .clk(clk), .rstn(rstn),
      .ld_start(ld_start[0]), .ld_valid(ld_valid[0]), .ld_byte(ld_byte[0]), .ld_end(ld_end[0]),
      .ld_busy(ld_busy[0]), .ld_done(ld_done[0]), .ld_overflow(ld_overflow[0]), .ld_words(ld_words0),
      .f_req(f_req[0]), .f_addr(f_addr[0]), .f_ready(f_ready[0]), .f_stall(f_stall[0]),
      .f_valid(f_valid[0]), .f_instr(f_instr[0]), .f_pc(f_pc[0]), .f_fault(f_fault[0])
   );

   instr_mem_loader #(.ADDRW(2)) u_dut1 (
      .clk(clk), .rstn(rstn),
      .ld_start(ld_start[1]), .ld_valid(ld_valid[1]), .ld_byte(ld_byte[1]), .ld_end(ld_end[1]),
      .ld_busy(ld_busy[1]), .ld_done(ld_done[1]), .ld_overflow(ld_overflow[1]), .ld_words(ld_words1),
      .f_req(f_req[1]), .f_addr(f_addr[1]), .f_ready(f_ready[1]), .f_stall(f_stall[1]),
      .f_valid(f_valid[1]), .f_instr(f_instr[1]), .f_pc(f_pc[1]), .f_fault(f_fault[1])
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] words(input int d);
      return (d == 0) ? {21'd0, ld_words0} : {29'd0, ld_words1};
   endfunction

   task automatic start_load(input int d, input string tag);
      ld_start[d] = 1'b1;
      tick();
      ld_start[d] = 1'b0;
      chk({tag, "_busy"}, ld_busy[d], 1);
      chk({tag, "_words0"}, words(d), 0);
   endtask

   task automatic send_byte(input int d, input logic [7:0] b);
      ld_valid[d] = 1'b1;
      ld_byte[d]  = b;
      tick();
      ld_valid[d] = 1'b0;
   endtask

   task automatic end_load(input int d, input string tag);
      ld_end[d] = 1'b1;
      tick();
      ld_end[d] = 1'b0;
      chk({tag, "_done1"}, ld_done[d], 1);
      chk({tag, "_idle"}, ld_busy[d], 0);
      tick();
      chk({tag, "_done0"}, ld_done[d], 0);
   endtask

   task automatic fetch_chk(input int d, input logic [31:0] addr, input logic [31:0] exp,
                            input logic expf, input string tag);
      f_req[d]   = 1'b1;
      f_addr[d]  = addr;
      f_stall[d] = 1'b0;
      #1;
      chk({tag, "_rdy"}, f_ready[d], 1);
      tick();
      f_req[d] = 1'b0;
      chk({tag, "_vld"}, f_valid[d], 1);
      chk({tag, "_instr"}, f_instr[d], exp);
      chk({tag, "_pc"}, f_pc[d], addr);
      chk({tag, "_fault"}, f_fault[d], expf);
      tick();
      chk({tag, "_drop"}, f_valid[d], 0);
   endtask

   initial begin
      rstn     = 1'b0;
      ld_start = '0;
      ld_valid = '0;
      ld_end   = '0;
      f_req    = '0;
      f_stall  = '0;
      for (int i = 0; i < 2; i++) begin
         ld_byte[i] = 8'h00;
         f_addr[i]  = 32'h0;
      end
      repeat (3) tick();

      chk("rst_busy", ld_busy[0], 0);
      chk("rst_done", ld_done[0], 0);
      chk("rst_ovf", ld_overflow[0], 0);
      chk("rst_words", words(0), 0);
      chk("rst_fvalid", f_valid[0], 0);
      chk("rst_ffault", f_fault[0], 0);
      chk("rst_finstr", f_instr[0], 0);
      chk("rst_fpc", f_pc[0], 0);
      chk("rst1_words", words(1), 0);
      chk("rst1_ovf", ld_overflow[1], 0);
      rstn = 1'b1;
      tick();

      // Two full words
      start_load(0, "r35");
      for (int i = 0; i < 8; i++) send_byte(0, p35[i]);
      chk("r35_words_pre", words(0), 2);
      end_load(0, "r35");
      chk("r35_words", words(0), 2);

      // Back-to-back fetches, one response per cycle
      f_req[0]  = 1'b1;
      f_addr[0] = 32'h0;
      tick();
      chk("b2b_v0", f_valid[0], 1);
      chk("b2b_i0", f_instr[0], 32'h0000_0013);
      f_addr[0] = 32'h4;
      tick();
      chk("b2b_v1", f_valid[0], 1);
      chk("b2b_i1", f_instr[0], 32'h0010_0093);
      chk("b2b_pc1", f_pc[0], 32'h4);
      f_req[0] = 1'b0;
      tick();
      chk("b2b_drop", f_valid[0], 0);

      // Stall the first response for three cycles while the next fetch waits
      f_req[0]  = 1'b1;
      f_addr[0] = 32'h0;
      tick();
      f_addr[0]  = 32'h4;
      f_stall[0] = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("stl_rdy", f_ready[0], 0);
         chk("stl_vld", f_valid[0], 1);
         chk("stl_instr", f_instr[0], 32'h0000_0013);
         chk("stl_pc", f_pc[0], 32'h0);
         if (i == 2) f_stall[0] = 1'b0;
         tick();
      end
      chk("stl_next_vld", f_valid[0], 1);
      chk("stl_next_instr", f_instr[0], 32'h0010_0093);
      chk("stl_next_pc", f_pc[0], 32'h4);
      f_req[0] = 1'b0;
      tick();
      chk("stl_drop", f_valid[0], 0);

      // Partial word, ignored restart mid-load, last byte together with ld_end
      start_load(0, "r36");
      send_byte(0, 8'hAA);
      send_byte(0, 8'hBB);
      ld_start[0] = 1'b1;
      send_byte(0, 8'hCC);
      ld_start[0] = 1'b0;
      chk("r36_busy", ld_busy[0], 1);
      send_byte(0, 8'hDD);
      ld_valid[0] = 1'b1;
      ld_byte[0]  = 8'hEE;
      ld_end[0]   = 1'b1;
      tick();
      ld_valid[0] = 1'b0;
      ld_end[0]   = 1'b0;
      chk("r36_done1", ld_done[0], 1);
      chk("r36_words", words(0), 2);
      tick();
      chk("r36_done0", ld_done[0], 0);
      fetch_chk(0, 32'h4, 32'h0000_00EE, 1'b0, "r36_w1");
      fetch_chk(0, 32'h0, 32'hDDCC_BBAA, 1'b0, "r36_w0");

      // Reset mid-word discards the pending partial word
      start_load(0, "r39");
      send_byte(0, 8'h11);
      send_byte(0, 8'h22);
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      chk("r39_busy", ld_busy[0], 0);
      chk("r39_words", words(0), 0);
      chk("r39_done", ld_done[0], 0);
      fetch_chk(0, 32'h0, 32'hDDCC_BBAA, 1'b0, "r39_w0");

`ifdef IMEM_FETCH_FAULT_EN
      fetch_chk(0, 32'h2, 32'h0000_0013, 1'b1, "flt_mis");
      fetch_chk(0, 32'h1000, 32'h0000_0013, 1'b1, "flt_oor");
      fetch_chk(0, 32'h4, 32'h0000_00EE, 1'b0, "flt_ok");
`else
      fetch_chk(0, 32'h1000, 32'hDDCC_BBAA, 1'b0, "alias_hi");
      fetch_chk(0, 32'h6, 32'h0000_00EE, 1'b0, "alias_lo");
`endif

      // Overflow on the 4-word instance
      start_load(1, "r37");
      for (int i = 1; i <= 16; i++) send_byte(1, 8'(i));
      chk("r37_ovf_pre", ld_overflow[1], 0);
      chk("r37_words_pre", words(1), 4);
      send_byte(1, 8'h11);
      chk("r37_ovf", ld_overflow[1], 1);
      end_load(1, "r37");
      chk("r37_words", words(1), 4);
      chk("r37_ovf_sticky", ld_overflow[1], 1);
      fetch_chk(1, 32'h0, 32'h0403_0201, 1'b0, "r37_w0");
      fetch_chk(1, 32'hC, 32'h100F_0E0D, 1'b0, "r37_w3");
      start_load(1, "r37b");
      chk("r37b_ovf_clr", ld_overflow[1], 0);
      end_load(1, "r37b");
      chk("r37b_words", words(1), 0);
      fetch_chk(1, 32'h0, 32'h0403_0201, 1'b0, "r37b_w0");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
